// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode, state, mux-select and trap-cause encodings for the multicycle control
package riscv_pkg;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;
  typedef enum logic [3:0] {
    C_OP, C_OP_IMM, C_LOAD, C_STORE, C_BRANCH, C_LUI,
    C_AUIPC, C_JAL, C_JALR, C_FENCE, C_SYSTEM, C_ILLEGAL
  } iclass_t;
  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_IMM     = 2'd1;
  localparam logic [1:0] PC_ALU     = 2'd2;
  localparam logic [1:0] A_RS1      = 2'd0;
  localparam logic [1:0] A_PC       = 2'd1;
  localparam logic [1:0] A_ZERO     = 2'd2;
  localparam logic       B_RS2      = 1'b0;
  localparam logic       B_IMM      = 1'b1;
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_BRANCH = 2'd2;
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;
  localparam logic [1:0] TC_ILLEGAL = 2'd0;
  localparam logic [1:0] TC_FETCH_TO = 2'd1;
  localparam logic [1:0] TC_DATA_TO = 2'd2;
  localparam logic [1:0] TC_ECALL   = 2'd3;
  function automatic logic retires_in_exec(iclass_t c);
    return c == C_BRANCH || c == C_FENCE;
  endfunction
endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// riscv_multicycle_ctrl_if: shared memory-port handshake between the control FSM and the memory
interface riscv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_is_fetch;
  logic mem_ready;
  modport master(output mem_req, mem_we, mem_is_fetch, input mem_ready);
  modport slave(input mem_req, mem_we, mem_is_fetch, output mem_ready);
endinterface

// File: rtl/riscv_opcode_class.sv
// riscv_opcode_class: maps the major opcode to an instruction class and flags unknown opcodes
module riscv_opcode_class
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       illegal
);
  // classify the major opcode; anything unlisted is illegal
  always_comb begin
    case (opcode)
      OP:       cls = C_OP;
      OP_IMM:   cls = C_OP_IMM;
      LOAD:     cls = C_LOAD;
      STORE:    cls = C_STORE;
      BRANCH:   cls = C_BRANCH;
      LUI:      cls = C_LUI;
      AUIPC:    cls = C_AUIPC;
      JAL:      cls = C_JAL;
      JALR:     cls = C_JALR;
      MISC_MEM: cls = C_FENCE;
      SYSTEM:   cls = C_SYSTEM;
      default:  cls = C_ILLEGAL;
    endcase
  end
  assign illegal = cls == C_ILLEGAL;
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multicycle RV32I control FSM with memory timeout and sticky trap
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  riscv_multicycle_ctrl_if.master        bus,
  input  logic [31:0]                    inst,
  input  logic                           branch_taken,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic [1:0]                     pc_src,
  output logic [1:0]                     alu_a_sel,
  output logic                           alu_b_sel,
  output logic [1:0]                     alu_op,
  output logic                           reg_write,
  output logic [1:0]                     wb_sel,
  output logic                           trap,
  output logic [1:0]                     trap_cause,
  output logic [2:0]                     state,
  output logic [31:0]                    instret
);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  state_t           st;
  iclass_t          cls;
  logic             illegal;
  logic             unused_inst;
  logic             timed_out;
  logic             mem_req;
  logic             mem_we;
  logic             mem_is_fetch;
  logic [CNT_W-1:0] wait_cnt;
  riscv_opcode_class u_class (
    .opcode (inst[6:0]),
    .cls    (cls),
    .illegal(illegal)
  );
  assign unused_inst      = ^inst[31:7];
  assign timed_out        = !bus.mem_ready && wait_cnt == WAIT_LAST;
  assign state            = st;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_is_fetch = mem_is_fetch;
  // sequencing, wait counter, retire counter and sticky trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_FETCH;
      instret    <= '0;
      trap_cause <= TC_ILLEGAL;
      wait_cnt   <= '0;
    end else begin
      case (st)
        S_FETCH: begin
          if (bus.mem_ready) st <= S_DECODE;
          else if (timed_out) begin
            st         <= S_TRAP;
            trap_cause <= TC_FETCH_TO;
          end else wait_cnt <= wait_cnt + CNT_W'(1);
        end
        S_DECODE: begin
          if (illegal || cls == C_SYSTEM) begin
            st         <= S_TRAP;
            trap_cause <= illegal ? TC_ILLEGAL : TC_ECALL;
          end else st <= S_EXEC;
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (retires_in_exec(cls)) begin
            st      <= S_FETCH;
            instret <= instret + 32'd1;
          end else st <= cls == C_LOAD || cls == C_STORE ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            st       <= cls == C_LOAD ? S_WB : S_FETCH;
            if (cls != C_LOAD) instret <= instret + 32'd1;
          end else if (timed_out) begin
            st         <= S_TRAP;
            trap_cause <= TC_DATA_TO;
          end else wait_cnt <= wait_cnt + CNT_W'(1);
        end
        S_WB: begin
          st       <= S_FETCH;
          wait_cnt <= '0;
          instret  <= instret + 32'd1;
        end
        S_TRAP: st <= S_TRAP;
        default: begin
          st       <= S_FETCH;
          wait_cnt <= '0;
        end
      endcase
    end
  end
  // control outputs decoded from state and opcode class, forced low during reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    trap         = 1'b0;
    if (rst_n) begin
      case (st)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          ir_write     = bus.mem_ready;
        end
        S_EXEC: begin
          alu_a_sel = cls == C_LUI ? A_ZERO : cls == C_AUIPC ? A_PC : A_RS1;
          alu_b_sel = cls inside {C_OP_IMM, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_JALR} ? B_IMM : B_RS2;
          alu_op    = cls inside {C_OP, C_OP_IMM} ? ALU_FUNCT : cls == C_BRANCH ? ALU_BRANCH : ALU_ADD;
          pc_write  = retires_in_exec(cls);
          pc_src    = cls == C_BRANCH && branch_taken ? PC_IMM : PC_PLUS4;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_we   = cls == C_STORE;
          pc_write = cls != C_LOAD && bus.mem_ready;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          wb_sel    = cls inside {C_JAL, C_JALR} ? WB_PC4 : cls == C_LOAD ? WB_MEM : WB_ALU;
          pc_src    = cls == C_JAL ? PC_IMM : cls == C_JALR ? PC_ALU : PC_PLUS4;
        end
        S_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences one shared memory port, the PC/IR registers, the ALU operand muxes and register-file writeback for each instruction. It steers the immediate generator's output into the ALU and the PC adder. It also detects illegal opcodes, ECALL/EBREAK and memory timeouts, and holds a sticky trap.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ready before a bus-error trap (range 1..65535)
CNT_W, 16, width of the wait counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  32  current IR contents (opcode inst[6:0])
branch_taken  in  1  comparator result from ALU, valid in EXEC
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store request (valid with mem_req)
mem_is_fetch  out  1  request is an instruction fetch (address = PC)
ir_write  out  1  load IR from memory data
pc_write  out  1  update PC
pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared
alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
alu_b_sel  out  1  0=rs2, 1=imm
alu_op  out  2  0=add, 1=funct3/funct7 decoded, 2=branch compare
reg_write  out  1  register-file write enable (x0 discarded by regfile)
wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4
trap  out  1  sticky trap flag
trap_cause  out  2  0=illegal opcode, 1=fetch timeout, 2=data timeout, 3=ECALL/EBREAK
state  out  3  FSM state, for debug
instret  out  32  retired-instruction counter, wraps at 2^32

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 recover to FETCH.
- Reset (rst_n low, asynchronous): state=FETCH, instret=0, trap=0, trap_cause=0, wait counter=0. All control outputs are 0 while rst_n is low.
- Outputs are decoded combinationally from state and inst. Every enable is 0 unless stated below.
- FETCH: mem_req=1, mem_is_fetch=1. When mem_ready=1, pulse ir_write=1 in that cycle and go to DECODE. Zero-wait memory is legal, so FETCH takes 1 cycle.
- DECODE: 1 cycle for regfile read.
  - Opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 0001111 go to EXEC.
  - Opcode 1110011 goes to TRAP with cause 3.
  - Any other opcode goes to TRAP with cause 0.
- EXEC:
  - OP: a=rs1, b=rs2, alu_op=1, then WB.
  - OP-IMM: a=rs1, b=imm, alu_op=1, then WB.
  - LUI: a=zero, b=imm, alu_op=0, then WB.
  - AUIPC: a=PC, b=imm, alu_op=0, then WB.
  - LOAD/STORE: a=rs1, b=imm, alu_op=0; the address is latched by the datapath ALUOut; then MEM.
  - BRANCH: alu_op=2, pc_write=1, pc_src = branch_taken ? 1 : 0; retire and go to FETCH.
  - JAL: go to WB.
  - JALR: a=rs1, b=imm, alu_op=0, then WB.
  - FENCE: pc_write=1, pc_src=0; retire and go to FETCH (treated as NOP).
- MEM: mem_req=1, mem_we=1 for stores. On mem_ready, a load goes to WB; a store pulses pc_write with pc_src=0, retires and goes to FETCH.
- WB: reg_write=1, pc_write=1.
  - JAL: wb_sel=2, pc_src=1.
  - JALR: wb_sel=2, pc_src=2.
  - LOAD: wb_sel=1, pc_src=0.
  - All others: wb_sel=0, pc_src=0.
  - Retire and go to FETCH. rd and PC are written in the same edge; the datapath uses the old PC for PC+4.
- Retire: instret increments by 1 on the edge that leaves the retiring state. It counts exactly once per completed instruction and never counts trapped instructions.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle while mem_req=1 and mem_ready=0.
  - When the counter reaches MEM_TIMEOUT without mem_ready, go to TRAP with cause 1 (FETCH) or cause 2 (MEM).
  - If mem_ready arrives in the same cycle the counter reaches MEM_TIMEOUT, the ready wins.
- TRAP: trap=1, trap_cause held, all enables 0, instret frozen. Only rst_n exits TRAP.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-request drops mem_req asynchronously. There is no partial-state carryover.
- Latency with zero-wait memory: branch and FENCE 3 cycles; ALU, LUI, AUIPC, JAL, JALR and store 4 cycles; load 5 cycles.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, MISC_MEM, SYSTEM);
  - state encodings;
  - pc_src, alu_a_sel, wb_sel and alu_op encodings;
  - trap_cause codes.
- One natural sub-module, riscv_opcode_class: a combinational classifier from inst[6:0] to instruction class plus illegal flag. The FSM, counters and output decode stay in the top module.

Test Plan:
- Reset low, then release with mem_ready=1 and inst=ADDI x1,x0,5 (0x00500093): states 0→1→2→4→0. In EXEC: alu_a_sel=0, alu_b_sel=1. In WB: reg_write=1, wb_sel=0. instret=1 after 4 cycles.
- LW (0x0000A083), mem_ready low for 3 cycles in MEM: mem_req held 4 cycles in MEM, then WB with wb_sel=1. Total 8 cycles; instret +1.
- BEQ (0x00000463), once with branch_taken=1 and once with 0: pc_write=1 in EXEC with pc_src=1 and 0 respectively. 3 cycles each, no reg_write.
- JALR (0x000080E7): EXEC a=0, b=1. WB reg_write=1, wb_sel=2, pc_src=2.
- inst=0x00000073 (ECALL): TRAP with cause 3; next, inst=0xFFFFFFFF: TRAP with cause 0. In both cases all enables stay 0 for 20 cycles and instret is unchanged.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: trap=1, cause=1 after 4 waiting cycles. Repeat with mem_ready=1 on the 4th cycle: no trap. Pulse rst_n low mid-fetch: mem_req=0 immediately.
